// File: rtl/pbe_pkg.sv
// Shared definitions for the pending-bit encoder: word/index widths, FSM states
// and a lowest-set-bit helper.
package pbe_pkg;

    localparam int IN_W  = 16;
    localparam int IDX_W = $clog2(IN_W);

    typedef enum logic {
        PBE_IDLE,
        PBE_EMIT
    } pbe_state_e;

    // Scans from the top down so the lowest set bit is the last one written.
    function automatic logic [IDX_W-1:0] lowest_set_index(input logic [IN_W-1:0] mask);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = IN_W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pbe_lsb_encoder.sv
// Combinational lowest-set-bit encoder with "anything set" and "exactly one bit
// set" flags for the remaining mask.
module pbe_lsb_encoder
    import pbe_pkg::*;
(
    input  logic [IN_W-1:0]  mask,
    output logic [IDX_W-1:0] index,
    output logic             any_set,
    output logic             one_hot
);

    assign index   = lowest_set_index(mask);
    assign any_set = |mask;
    // Clearing the lowest set bit leaves nothing only when exactly one was set.
    assign one_hot = any_set && ((mask & (mask - IN_W'(1))) == '0);

endmodule

// File: rtl/pending_bit_encoder.sv
// Accepts a request word and emits the index of each set bit, lowest first, one
// per output handshake. Optional out_last flag enabled by `PBE_LAST_FLAG_EN.
module pending_bit_encoder
    import pbe_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             busy
`ifdef PBE_LAST_FLAG_EN
    ,
    output logic             out_last
`endif
);

    pbe_state_e       state_reg, state_next;
    logic [IN_W-1:0]  pending_reg, pending_next;
    logic             out_valid_reg;
    logic [IDX_W-1:0] out_index_reg;
    logic             busy_reg;
    logic             last_reg;
    logic             accept;

    logic [IDX_W-1:0] next_index;
    logic             next_any;
    logic             next_one_hot;

    // Outputs are registered from the encoded next pending value, so the index
    // shown always matches the pending register with no path from in_*.
    pbe_lsb_encoder u_next_enc (
        .mask    (pending_next),
        .index   (next_index),
        .any_set (next_any),
        .one_hot (next_one_hot)
    );

    always_comb begin
        in_ready     = 1'b0;
        pending_next = pending_reg;
        case (state_reg)
            PBE_IDLE: in_ready = 1'b1;
            // last_reg marks a single remaining bit: its handshake frees the slot
            PBE_EMIT: in_ready = last_reg && out_ready;
            default:  in_ready = 1'b0;
        endcase
        accept = in_valid && in_ready;
        if (accept) begin
            pending_next = in_word;
        end else if (state_reg == PBE_EMIT && out_ready) begin
            pending_next = pending_reg & (pending_reg - IN_W'(1));
        end
        state_next = next_any ? PBE_EMIT : PBE_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= PBE_IDLE;
            pending_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_index_reg <= '0;
            busy_reg      <= 1'b0;
            last_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            out_valid_reg <= (state_next == PBE_EMIT);
            out_index_reg <= next_index;
            busy_reg      <= next_any;
            last_reg      <= next_one_hot;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_index = out_index_reg;
    assign busy      = busy_reg;
`ifdef PBE_LAST_FLAG_EN
    assign out_last  = last_reg;
`endif

endmodule

// File: tb/tb_pending_bit_encoder.sv
// Directed testbench for pending_bit_encoder; builds with or without
// PBE_LAST_FLAG_EN.
module tb_pending_bit_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_index;
    logic        busy;
`ifdef PBE_LAST_FLAG_EN
    logic        out_last;
`endif

    int passes = 0;
    int checks = 0;

    pending_bit_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .busy      (busy)
`ifdef PBE_LAST_FLAG_EN
        ,
        .out_last  (out_last)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_last(input string tag, input logic exp);
`ifdef PBE_LAST_FLAG_EN
        chk(tag, 32'(out_last), 32'(exp));
`else
        if (exp === 1'bx) $display("unused %s", tag);
`endif
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_idx [4];
        int count;
        bit done;

        // 1: reset with in_valid high
        rst_n = 1'b0; in_valid = 1'b1; in_word = 16'hABCD; out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_index", 32'(out_index), 32'd0);
        chk_last("rst_out_last", 1'b0);
        in_valid = 1'b0;
        #10;
        rst_n = 1'b1;
        tick();

        // 2: single bit word
        in_word = 16'h0001; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("t2_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; in_word = 16'hFFFF;
        #1;
        chk("t2_out_valid", 32'(out_valid), 32'd1);
        chk("t2_out_index", 32'(out_index), 32'd0);
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_in_ready_last", 32'(in_ready), 32'd1);
        chk_last("t2_out_last", 1'b1);
        tick();
        chk("t2_idle_valid", 32'(out_valid), 32'd0);
        chk("t2_idle_busy", 32'(busy), 32'd0);

        // 3: 8421 streaming, back-to-back reload with 0006, then a zero word
        exp_idx[0] = 4'd0; exp_idx[1] = 4'd5; exp_idx[2] = 4'd10; exp_idx[3] = 4'd15;
        in_word = 16'h8421; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("t3_valid_%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("t3_index_%0d", k), 32'(out_index), 32'(exp_idx[k]));
            if (k == 2) chk("t3_in_ready_mid", 32'(in_ready), 32'd0);
            if (k == 3) begin
                chk("t3_in_ready_last", 32'(in_ready), 32'd1);
                chk_last("t3_out_last", 1'b1);
                in_valid = 1'b1; in_word = 16'h0006;
            end
            tick();
        end
        #1;
        chk("t3_b2b_valid", 32'(out_valid), 32'd1);
        chk("t3_b2b_index1", 32'(out_index), 32'd1);
        chk("t3_b2b_in_ready", 32'(in_ready), 32'd0);
        tick();
        in_word = 16'h0000;
        #1;
        chk("t3_b2b_index2", 32'(out_index), 32'd2);
        chk("t3_b2b_in_ready2", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t3_zero_valid", 32'(out_valid), 32'd0);
        chk("t3_zero_busy", 32'(busy), 32'd0);
        chk("t3_zero_in_ready", 32'(in_ready), 32'd1);

        // 4: backpressure on 0300
        out_ready = 1'b0; in_word = 16'h0300; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_word = 16'h00F0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t4_hold_valid_%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("t4_hold_index_%0d", k), 32'(out_index), 32'd8);
            chk($sformatf("t4_hold_busy_%0d", k), 32'(busy), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("t4_index8", 32'(out_index), 32'd8);
        chk_last("t4_last8", 1'b0);
        tick();
        chk("t4_index9", 32'(out_index), 32'd9);
        chk_last("t4_last9", 1'b1);
        tick();
        chk("t4_done_valid", 32'(out_valid), 32'd0);

        // 5: zero word dropped
        in_word = 16'h0000; in_valid = 1'b1;
        #1;
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_in_ready_after", 32'(in_ready), 32'd1);

        // all-ones word takes exactly 16 handshakes
        in_word = 16'hFFFF; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        count = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (out_valid) begin
                chk($sformatf("ones_index_%0d", count), 32'(out_index), 32'(count));
                count++;
            end else begin
                done = 1'b1;
            end
            tick();
        end
        chk("ones_count", 32'(count), 32'd16);

        // 6: reset in the middle of an FFFF word
        in_word = 16'hFFFF; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("t6_index_%0d", k), 32'(out_index), 32'(k));
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_index", 32'(out_index), 32'd0);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t6_post_valid_%0d", k), 32'(out_valid), 32'd0);
            chk($sformatf("t6_post_busy_%0d", k), 32'(busy), 32'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
